// File: rtl/pipe_hazard_pkg.sv
// Latency classes and helpers shared by the hazard controller and its scoreboard.
package pipe_hazard_pkg;
  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_LONG = 2'd2,
    LAT_RSVD = 2'd3
  } lat_cls_e;

  // The reserved class is handled like LONG so that an unknown producer is never under-waited.
  function automatic int lat_of(input logic [1:0] cls, input int alu, input int ld, input int lng);
    case (lat_cls_e'(cls))
      LAT_ALU:  return alu;
      LAT_LOAD: return ld;
      default:  return lng;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage <-> hazard controller bundle: slave is the controller, master is the pipeline side.
interface pipe_hazard_ctrl_if #(parameter int RW = 5, parameter int CNT_W = 32) ();
  logic             ext_stall;
  logic             id_valid;
  logic [RW-1:0]    id_rs, id_rt;
  logic             id_rs_used, id_rt_used;
  logic             id_src_in_id;
  logic             id_wr_en;
  logic [RW-1:0]    id_rd;
  logic [1:0]       id_lat_cls;
  logic             id_redirect;
  logic             if_stall, id_bubble, if_flush;
  logic [CNT_W-1:0] perf_stall, perf_load_use, perf_br_stall, perf_flush;

  modport slave (
    input  ext_stall, id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_src_in_id,
           id_wr_en, id_rd, id_lat_cls, id_redirect,
    output if_stall, id_bubble, if_flush, perf_stall, perf_load_use, perf_br_stall, perf_flush
  );
  modport master (
    output ext_stall, id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_src_in_id,
           id_wr_en, id_rd, id_lat_cls, id_redirect,
    input  if_stall, id_bubble, if_flush, perf_stall, perf_load_use, perf_br_stall, perf_flush
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard with a LOAD tag; set beats decrement, r0 never busy.
module hazard_scoreboard
  import pipe_hazard_pkg::*;
#(
  parameter int RW  = 5,
  parameter int CW  = 3,
  parameter int NRD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec_en_i,
  input  logic                     set_en_i,
  input  logic [RW-1:0]            set_addr_i,
  input  logic [CW-1:0]            set_val_i,
  input  logic                     set_load_i,
  input  logic [NRD-1:0][RW-1:0]   rd_addr_i,
  output logic [NRD-1:0]           busy_ex_o,
  output logic [NRD-1:0]           busy_id_o,
  output logic [NRD-1:0]           is_load_o
);
  localparam int NREG = 1 << RW;

  logic [NREG-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]         tag_q, tag_d;

  always_comb begin
    cnt_d = cnt_q;
    tag_d = tag_q;
    if (dec_en_i) begin
      for (int r = 0; r < NREG; r++)
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
    end
    if (set_en_i && set_addr_i != '0) begin
      cnt_d[set_addr_i] = set_val_i;
      tag_d[set_addr_i] = set_load_i;
    end
    cnt_d[0] = '0;
    tag_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tag_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tag_q <= tag_d;
    end
  end

  // busy_ex: result not yet forwardable to EX next cycle; busy_id: not yet in the regfile/bypass for ID.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign busy_id_o[p] = cnt_q[rd_addr_i[p]] != '0;
    assign busy_ex_o[p] = cnt_q[rd_addr_i[p]] > CW'(1);
    assign is_load_o[p] = tag_q[rd_addr_i[p]];
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard hazard controller beside ID: stall/bubble/flush plus optional perf counters
// (built when HAZARD_PERF_CNT_EN is defined, otherwise tied to zero).
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int RW       = 5,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int LONG_LAT = 4,
  parameter int CNT_W    = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int CW = $clog2(max3(ALU_LAT, LOAD_LAT, LONG_LAT) + 1);

  logic [1:0][RW-1:0] rd_addr;
  logic [1:0]         busy_ex, busy_id, is_load, used, haz;
  logic               issue, set_en, load_use;
  logic [CW-1:0]      set_val;

  assign rd_addr = {hz.id_rt, hz.id_rs};
  assign used    = {hz.id_rt_used, hz.id_rs_used};
  assign haz     = used & (hz.id_src_in_id ? busy_id : busy_ex);

  assign hz.if_stall  = hz.id_valid & (|haz) & ~hz.ext_stall;
  assign hz.id_bubble = hz.if_stall;
  assign hz.if_flush  = hz.id_valid & hz.id_redirect & ~hz.if_stall & ~hz.ext_stall;

  assign issue    = hz.id_valid & ~hz.if_stall & ~hz.ext_stall;
  assign set_en   = issue & hz.id_wr_en;
  assign set_val  = CW'(lat_of(hz.id_lat_cls, ALU_LAT, LOAD_LAT, LONG_LAT));
  assign load_use = hz.if_stall & ~hz.id_src_in_id & (|(haz & is_load));

  hazard_scoreboard #(.RW(RW), .CW(CW), .NRD(2)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .dec_en_i   (~hz.ext_stall),
    .set_en_i   (set_en),
    .set_addr_i (hz.id_rd),
    .set_val_i  (set_val),
    .set_load_i (hz.id_lat_cls == LAT_LOAD),
    .rd_addr_i  (rd_addr),
    .busy_ex_o  (busy_ex),
    .busy_id_o  (busy_id),
    .is_load_o  (is_load)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [3:0]            ev;
  logic [3:0][CNT_W-1:0] perf_q, perf_d;

  assign ev = {hz.if_flush, hz.if_stall & hz.id_src_in_id, load_use, hz.if_stall};

  always_comb begin
    perf_d = perf_q;
    for (int i = 0; i < 4; i++)
      if (ev[i] && !(&perf_q[i])) perf_d[i] = perf_q[i] + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign hz.perf_stall    = perf_q[0];
  assign hz.perf_load_use = perf_q[1];
  assign hz.perf_br_stall = perf_q[2];
  assign hz.perf_flush    = perf_q[3];
`else
  logic unused_perf;
  assign unused_perf      = load_use;
  assign hz.perf_stall    = '0;
  assign hz.perf_load_use = '0;
  assign hz.perf_br_stall = '0;
  assign hz.perf_flush    = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed per-cycle vector table for pipe_hazard_ctrl plus a mid-cycle reset sequence.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.RW(5), .CNT_W(32)) hz ();
  pipe_hazard_ctrl #(.RW(5), .ALU_LAT(1), .LOAD_LAT(2), .LONG_LAT(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  typedef struct {
    logic       rst, ext, vld;
    logic [4:0] rs;
    logic       rsu;
    logic [4:0] rt;
    logic       rtu, sid, we;
    logic [4:0] rd;
    logic [1:0] cls;
    logic       redir;
    logic       e_stall, e_flush;
  } vec_t;

  vec_t tbl[$];
  vec_t t;
  int   nvec  = 0;
  int   nfail = 0;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] EP_STALL = 7, EP_LU = 1, EP_BR = 3, EP_FL = 2;
`else
  localparam logic [31:0] EP_STALL = 0, EP_LU = 0, EP_BR = 0, EP_FL = 0;
`endif

  task automatic add(input logic r, e, v, input logic [4:0] rs, input logic rsu,
                     input logic [4:0] rt, input logic rtu, input logic sid, we,
                     input logic [4:0] rd, input logic [1:0] cls, input logic redir, es, ef);
    vec_t x;
    x.rst = r; x.ext = e; x.vld = v; x.rs = rs; x.rsu = rsu; x.rt = rt; x.rtu = rtu;
    x.sid = sid; x.we = we; x.rd = rd; x.cls = cls; x.redir = redir;
    x.e_stall = es; x.e_flush = ef;
    tbl.push_back(x);
  endtask

  task automatic drive(input vec_t x);
    rst = x.rst;
    hz.ext_stall = x.ext; hz.id_valid = x.vld;
    hz.id_rs = x.rs; hz.id_rs_used = x.rsu; hz.id_rt = x.rt; hz.id_rt_used = x.rtu;
    hz.id_src_in_id = x.sid; hz.id_wr_en = x.we; hz.id_rd = x.rd; hz.id_lat_cls = x.cls;
    hz.id_redirect = x.redir;
  endtask

  task automatic chk_perf(input string nm, input logic [31:0] s, l, b, f);
    nvec++;
    if (hz.perf_stall !== s || hz.perf_load_use !== l || hz.perf_br_stall !== b || hz.perf_flush !== f) begin
      nfail++;
      $display("FAIL %s: perf got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", nm,
               hz.perf_stall, hz.perf_load_use, hz.perf_br_stall, hz.perf_flush, s, l, b, f);
    end
  endtask

  task automatic chk_bit(input string nm, input logic got, want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  initial begin
    //   rst ext vld  rs rsu  rt rtu sid  we rd cls redir  stall flush
    add(1,0,0,  0,0,  0,0, 0,  0, 0,0, 0,  0,0); // 0 reset
    add(0,0,1,  0,0,  0,0, 0,  1, 8,0, 0,  0,0); // 1 ALU -> r8
    add(0,0,1,  8,1,  0,0, 1,  0, 0,0, 1,  1,0); // 2 beq r8 stalls
    add(0,0,1,  8,1,  0,0, 1,  0, 0,0, 1,  0,1); // 3 issues, flush
    add(0,0,1,  0,0,  0,0, 0,  1, 9,1, 0,  0,0); // 4 lw r9
    add(0,0,1,  9,1,  3,1, 0,  1,11,0, 0,  1,0); // 5 add r9 load-use
    add(0,0,1,  9,1,  3,1, 0,  1,11,0, 0,  0,0); // 6
    add(0,0,1,  0,0,  0,0, 0,  1, 9,1, 0,  0,0); // 7 lw r9
    add(0,0,1,  0,0,  9,1, 1,  0, 0,0, 0,  1,0); // 8 beq r9 (rt)
    add(0,0,1,  0,0,  9,1, 1,  0, 0,0, 0,  1,0); // 9
    add(0,0,1,  0,0,  9,1, 1,  0, 0,0, 1,  0,1); // 10
    add(0,0,1,  0,0,  0,0, 0,  1,10,2, 0,  0,0); // 11 mult -> r10
    add(0,0,1, 10,1,  0,0, 0,  0, 0,0, 0,  1,0); // 12
    add(0,1,1, 10,1,  0,0, 0,  0, 0,0, 0,  0,0); // 13 ext stall
    add(0,1,1, 10,1,  0,0, 0,  0, 0,0, 0,  0,0); // 14
    add(0,0,1, 10,1,  0,0, 0,  0, 0,0, 0,  1,0); // 15
    add(0,0,1, 10,1,  0,0, 0,  0, 0,0, 0,  1,0); // 16
    add(0,0,1, 10,1,  0,0, 0,  0, 0,0, 0,  0,0); // 17
    add(0,0,1,  0,0,  0,0, 0,  1, 0,1, 0,  0,0); // 18 lw r0
    add(0,0,1,  0,1,  0,1, 1,  0, 0,0, 0,  0,0); // 19 beq r0,r0
    add(0,0,1,  0,0,  0,0, 0,  1,12,1, 0,  0,0); // 20 lw r12
    add(0,0,1, 12,1,  0,0, 1,  0, 0,0, 0,  1,0); // 21 beq r12
    add(1,0,1, 12,1,  0,0, 1,  0, 0,0, 0,  0,0); // 22 reset mid-stall
    add(0,0,1, 12,1,  0,0, 1,  0, 0,0, 0,  0,0); // 23
    add(0,0,1,  0,0,  0,0, 0,  1, 5,1, 0,  0,0); // 24 lw r5
    add(0,0,1,  0,0,  0,0, 0,  1, 5,0, 0,  0,0); // 25 ALU r5
    add(0,0,0,  0,0,  0,0, 0,  0, 0,0, 0,  0,0); // 26
    add(0,0,1,  5,1,  0,0, 0,  0, 0,0, 0,  0,0); // 27 add r5
    add(0,0,1,  0,0,  0,0, 0,  1, 6,2, 0,  0,0); // 28 mult r6
    add(0,0,1,  0,0,  0,0, 0,  1, 6,0, 0,  0,0); // 29 ALU r6 overrides
    add(0,0,1,  6,1,  0,0, 0,  0, 0,0, 0,  0,0); // 30 add r6
    add(0,0,1,  0,0,  0,0, 0,  1, 7,2, 0,  0,0); // 31 mult r7
    add(0,0,0,  7,1,  0,0, 1,  0, 0,0, 1,  0,0); // 32 invalid ID
    add(0,0,1,  7,1,  0,0, 1,  0, 0,0, 1,  1,0); // 33 stalled redirect
    add(0,1,1,  0,0,  0,0, 0,  0, 0,0, 1,  0,0); // 34 redirect under ext stall

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      @(posedge clk); #1;
      drive(t);
      @(negedge clk);
      nvec++;
      if (hz.if_stall !== t.e_stall || hz.id_bubble !== t.e_stall || hz.if_flush !== t.e_flush) begin
        nfail++;
        $display("FAIL vec%0d: stall=%b bubble=%b flush=%b want stall=%b bubble=%b flush=%b",
                 i, hz.if_stall, hz.id_bubble, hz.if_flush, t.e_stall, t.e_stall, t.e_flush);
      end
      if (i == 17) chk_perf("perf_after_mult", EP_STALL, EP_LU, EP_BR, EP_FL);
      if (i == 23) chk_perf("perf_after_reset", 0, 0, 0, 0);
    end

    t = tbl[20];
    @(posedge clk); #1; drive(t);
    t = tbl[21];
    @(posedge clk); #1; drive(t);
    #2 chk_bit("pre_reset_stall", hz.if_stall, 1'b1);
    #1 rst = 1'b1;
    #1 chk_bit("async_reset_stall", hz.if_stall, 1'b0);
    chk_bit("async_reset_cnt_zero", dut.u_sb.cnt_q == '0, 1'b1);
    chk_bit("async_reset_tag_zero", dut.u_sb.tag_q == '0, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk) chk_bit("post_reset_stall", hz.if_stall, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Scoreboard-based hazard controller for the 5-stage MIPS pipeline. It replaces fixed load-use and branch compare logic with a per-register countdown scoreboard. Stalls are therefore correct for any producer latency: ALU, load, or long-latency multiply/divide. It sits beside the ID stage. It drives the PC/IF_ID hold, the ID_EX bubble and the IF_ID flush. Optional stall performance counters are included.

## Interface
- Clock `clk`, one domain. Reset `rst`, asynchronous, active-high.
- `RW`, 5: register address width; 2^RW registers, register 0 is never busy.
- `ALU_LAT`, 1: scoreboard load value for class ALU.
- `LOAD_LAT`, 2: load value for class LOAD.
- `LONG_LAT`, 4: load value for class LONG (mul/div).
- `CNT_W`, 32: perf counter width.
- `clk  in  1`  pipeline clock
- `rst  in  1`  async active-high reset
- `ext_stall  in  1`  memory wait; freezes whole pipe
- `id_valid  in  1`  ID holds a real instruction
- `id_rs, id_rt  in  RW`  source registers
- `id_rs_used, id_rt_used  in  1`  source actually read
- `id_src_in_id  in  1`  operands consumed in ID (branch, jr)
- `id_wr_en  in  1`  instruction writes a register
- `id_rd  in  RW`  destination
- `id_lat_cls  in  2`  0 ALU, 1 LOAD, 2 LONG, 3 reserved (treated as LONG)
- `id_redirect  in  1`  ID resolved a taken branch/jump
- `if_stall  out  1`  hold PC and IF_ID
- `id_bubble  out  1`  zero ID_EX control signals
- `if_flush  out  1`  clear IF_ID
- `perf_stall, perf_load_use, perf_br_stall, perf_flush  out  CNT_W`  counters

## Operation
- Scoreboard: one counter `c[r]` per register, width clog2(max latency + 1).
- Hazard on a used source s (s ≠ 0) when `c[s] > 1`, or when `c[s] > 0` and `id_src_in_id`.
- `if_stall = id_valid & any_hazard & ~ext_stall`.
- `id_bubble = if_stall`.
- `if_flush = id_valid & id_redirect & ~if_stall & ~ext_stall`.
- Issue means `id_valid & ~if_stall & ~ext_stall`.
- On issue with `id_wr_en` and `id_rd ≠ 0`: `c[id_rd]` <= latency of `id_lat_cls`.
- Every other counter with `c > 0` decrements each cycle that `ext_stall` = 0.
- Set and decrement on the same register in the same cycle: set wins.
- While `ext_stall` = 1, counters hold and no set occurs.
- Writes to register 0 are ignored.
- Load-use stall is classified as: any hazard whose source counter was set by class LOAD and `id_src_in_id` = 0.
- Needs a 1-bit per-register class tag, set with the counter.

## Timing
- Outputs are combinational from the registered scoreboard plus ID inputs. Zero-cycle response.
- Resulting stall counts:
  - ALU → EX consumer: 0
  - ALU → branch: 1
  - LOAD → EX consumer: 1
  - LOAD → branch: 2
  - LONG → EX consumer: LONG_LAT−1
- Reset: all counters and tags 0, perf counters 0. All outputs 0 while `id_valid` = 0.
- Reset asserted mid-stall clears the scoreboard immediately. `if_stall` drops in the same cycle.
- Redirect while stalled: no flush until the stall clears. The flush then occurs in the issue cycle.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: four saturating CNT_W counters, each incrementing by one per event cycle:
  - `perf_stall`: cycles with `if_stall`
  - `perf_load_use`: cycles with a load-use stall
  - `perf_br_stall`: cycles with `if_stall & id_src_in_id`
  - `perf_flush`: cycles with `if_flush`
- Undefined: counters are not built; outputs tied to 0.

## Structure
- Package `pipe_hazard_pkg`: latency class encodings (LAT_ALU, LAT_LOAD, LAT_LONG) and a function mapping class to latency.
- Sub-module `hazard_scoreboard`: counter/tag array with set port, decrement enable, two read ports returning (busy_ex, busy_id, is_load).
- Top level: hazard combine, flush, perf counters.

## Test plan
- ALU writes r8, then `beq r8` next → `if_stall` = 1 for exactly 1 cycle, then `if_flush` = 1 if redirect.
- `lw r9`, then `add` using r9 → 1 stall cycle. `perf_load_use` increments by 1.
- `lw r9`, then `beq r9` → 2 stall cycles. `perf_br_stall` = 2.
- `mult`-class (LONG_LAT=4) writing r10, then dependent `add` → 3 stall cycles. `ext_stall` pulsed for 2 cycles mid-wait → stall extended by exactly 2.
- Write to r0 with LOAD class, then consumer of r0 → no stall. Reset pulse mid-stall → `if_stall` low immediately, all counters 0.
- Back-to-back producers to r5 (LOAD then ALU): second set overrides the first. A consumer two cycles later sees an ALU dependency → 0 stalls for an EX consumer.
